// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port integer register file with dual writeback lanes and pending scoreboard
module reg_file_mp #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int RESET_MODE = 1,
  parameter int BYPASS     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   r_addr,
  output logic [NUM_RD*XLEN-1:0]     r_data,
  output logic [NUM_RD-1:0]          r_pend,
  input  logic                       w0_en,
  input  logic [ADDR_W-1:0]          w0_addr,
  input  logic [XLEN-1:0]            w0_data,
  input  logic                       w1_en,
  input  logic [ADDR_W-1:0]          w1_addr,
  input  logic [XLEN-1:0]            w1_data,
  input  logic                       mark_en,
  input  logic [ADDR_W-1:0]          mark_addr,
  output logic                       pend_any
);

  localparam int DEPTH = 2 ** ADDR_W;

  function automatic logic [XLEN-1:0] reset_val(input int idx);
    logic [XLEN-1:0] v;
    v = XLEN'(1) << idx;
    if (RESET_MODE != 1 || idx == 0 || idx >= XLEN) begin
      v = '0;
    end
    return v;
  endfunction

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  logic w0_ok;
  logic w1_ok;
  logic mark_ok;

  // Qualified enables: nothing commits or forwards while reset is held.
  assign w0_ok   = rst_n && w0_en   && !((ZERO_REG != 0) && (w0_addr   == '0));
  assign w1_ok   = rst_n && w1_en   && !((ZERO_REG != 0) && (w1_addr   == '0));
  assign mark_ok = rst_n && mark_en && !((ZERO_REG != 0) && (mark_addr == '0));

  // w1 is applied after w0 so it wins on an address clash; mark is applied last
  // because the issuing instruction is newer than either retiring one.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (w0_ok) begin
      mem_d[w0_addr]  = w0_data;
      pend_d[w0_addr] = 1'b0;
    end
    if (w1_ok) begin
      mem_d[w1_addr]  = w1_data;
      pend_d[w1_addr] = 1'b0;
    end
    if (mark_ok) begin
      pend_d[mark_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= reset_val(i);
      end
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              hit0;
    logic              hit1;
    logic [XLEN-1:0]   data;
    logic              pend;

    assign addr    = r_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit1    = (BYPASS != 0) && w1_ok && (w1_addr == addr);
    assign hit0    = (BYPASS != 0) && w0_ok && (w0_addr == addr);

    // A forwarded value is already resolved, so the port reports it as not pending.
    always_comb begin
      data = mem_q[addr];
      pend = pend_q[addr];
      if (hit1) begin
        data = w1_data;
        pend = 1'b0;
      end else if (hit0) begin
        data = w0_data;
        pend = 1'b0;
      end
      if (is_zero) begin
        data = '0;
        pend = 1'b0;
      end
    end

    assign r_data[k*XLEN +: XLEN] = data;
    assign r_pend[k]              = pend;
  end

  assign pend_any = |pend_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - randomized bench for reg_file_mp, bypass and non-bypass builds side by side
module tb_reg_file_mp;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [NUM_RD*ADDR_W-1:0] r_addr;
  logic [NUM_RD*XLEN-1:0]   r_data_b, r_data_n;
  logic [NUM_RD-1:0]        r_pend_b, r_pend_n;
  logic                     pend_any_b, pend_any_n;
  logic                     w0_en, w1_en, mark_en;
  logic [ADDR_W-1:0]        w0_addr, w1_addr, mark_addr;
  logic [XLEN-1:0]          w0_data, w1_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] m_reg [DEPTH];
  bit              m_pend [DEPTH];

  always #5 clk = ~clk;

  reg_file_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_data(r_data_b), .r_pend(r_pend_b),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .pend_any(pend_any_b)
  );

  reg_file_mp #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_data(r_data_n), .r_pend(r_pend_n),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .pend_any(pend_any_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reset_val(input int i);
    logic [63:0] one;
    one = 64'd1;
    if (i == 0 || i >= XLEN) return 32'h0;
    return 32'(one << i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = reset_val(i);
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic bit lands(input logic en, input logic [ADDR_W-1:0] wa, input int a);
    return rst_n && en && (int'(wa) == a) && (a != 0);
  endfunction

  function automatic logic [31:0] exp_data(input bit byp, input int a);
    if (a == 0) return 32'h0;
    if (byp && lands(w1_en, w1_addr, a)) return w1_data;
    if (byp && lands(w0_en, w0_addr, a)) return w0_data;
    return m_reg[a];
  endfunction

  function automatic logic [31:0] exp_pend(input bit byp, input int a);
    if (a == 0) return 32'h0;
    if (byp && (lands(w1_en, w1_addr, a) || lands(w0_en, w0_addr, a))) return 32'h0;
    return {31'h0, m_pend[a]};
  endfunction

  function automatic logic [31:0] exp_any();
    bit any;
    any = 1'b0;
    foreach (m_pend[i]) any |= m_pend[i];
    return {31'h0, any};
  endfunction

  task automatic check_all(input string tag);
    int a;
    for (int k = 0; k < NUM_RD; k++) begin
      a = int'(r_addr[k*ADDR_W +: ADDR_W]);
      chk($sformatf("%s_rd%0d_data_byp", tag, k), r_data_b[k*XLEN +: XLEN], exp_data(1'b1, a));
      chk($sformatf("%s_rd%0d_data_nobyp", tag, k), r_data_n[k*XLEN +: XLEN], exp_data(1'b0, a));
      chk($sformatf("%s_rd%0d_pend_byp", tag, k), {31'h0, r_pend_b[k]}, exp_pend(1'b1, a));
      chk($sformatf("%s_rd%0d_pend_nobyp", tag, k), {31'h0, r_pend_n[k]}, exp_pend(1'b0, a));
    end
    chk({tag, "_pend_any_byp"}, {31'h0, pend_any_b}, exp_any());
    chk({tag, "_pend_any_nobyp"}, {31'h0, pend_any_n}, exp_any());
  endtask

  // Commit the current inputs into the model as the next rising edge will.
  task automatic model_clock();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (w0_en && w0_addr != 0) begin
      m_reg[w0_addr]  = w0_data;
      m_pend[w0_addr] = 1'b0;
    end
    if (w1_en && w1_addr != 0) begin
      m_reg[w1_addr]  = w1_data;
      m_pend[w1_addr] = 1'b0;
    end
    if (mark_en && mark_addr != 0) m_pend[mark_addr] = 1'b1;
  endtask

  task automatic step(input string tag,
                      input bit e0, input int a0, input logic [31:0] d0,
                      input bit e1, input int a1, input logic [31:0] d1,
                      input bit me, input int ma, input int ra0, input int ra1);
    @(negedge clk);
    w0_en = e0; w0_addr = a0[ADDR_W-1:0]; w0_data = d0;
    w1_en = e1; w1_addr = a1[ADDR_W-1:0]; w1_data = d1;
    mark_en = me; mark_addr = ma[ADDR_W-1:0];
    r_addr = {ra1[ADDR_W-1:0], ra0[ADDR_W-1:0]};
    #1 check_all(tag);
    model_clock();
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, 3));
    return int'($urandom_range(0, DEPTH-1));
  endfunction

  initial begin
    w0_en = 0; w0_addr = 0; w0_data = 0;
    w1_en = 0; w1_addr = 0; w1_data = 0;
    mark_en = 0; mark_addr = 0;
    r_addr = {5'd1, 5'd0};
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all("rst_a");
    chk("rst_x0", r_data_b[31:0], 32'h0);
    chk("rst_x1", r_data_b[63:32], 32'h2);
    r_addr = {5'd31, 5'd5};
    #1 check_all("rst_b");
    chk("rst_x5", r_data_b[31:0], 32'h20);
    chk("rst_x31", r_data_n[63:32], 32'h8000_0000);
    rst_n = 1'b1;

    step("wr7", 1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 7, 1);
    chk("wr7_byp", r_data_b[31:0], 32'hDEAD_BEEF);
    chk("wr7_nobyp_old", r_data_n[31:0], 32'h80);
    step("rd7", 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("rd7_nobyp_new", r_data_n[31:0], 32'hDEAD_BEEF);

    step("wr3", 1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 3, 7);
    chk("wr3_byp_w1", r_data_b[31:0], 32'h22);
    step("rd3", 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    chk("rd3_w1_wins", r_data_n[31:0], 32'h22);

    step("wr0", 1, 0, 32'h1234, 1, 0, 32'h1234, 0, 0, 0, 0);
    chk("wr0_byp", r_data_b[31:0], 32'h0);
    step("rd0", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("rd0_after", r_data_n[31:0], 32'h0);

    step("mk9", 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step("wb9", 0, 0, 0, 1, 9, 32'h55, 0, 0, 9, 0);
    chk("wb9_pend_fwd", {31'h0, r_pend_b[0]}, 32'h0);
    chk("wb9_pend_stored", {31'h0, r_pend_n[0]}, 32'h1);
    chk("wb9_any", {31'h0, pend_any_b}, 32'h1);
    step("clr9", 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("clr9_any", {31'h0, pend_any_b}, 32'h0);

    step("mk4", 1, 4, 32'hAAAA, 0, 0, 0, 1, 4, 4, 0);
    step("p4", 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    chk("p4_pend", {31'h0, r_pend_b[0]}, 32'h1);
    chk("p4_data", r_data_b[31:0], 32'hAAAA);

    @(negedge clk);
    w0_en = 1; w0_addr = 4; w0_data = 32'h77; mark_en = 1; mark_addr = 6;
    r_addr = {5'd6, 5'd4};
    #1 check_all("pre_rst");
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all("mid_rst");
    chk("mid_rst_x4", r_data_b[31:0], 32'h10);
    chk("mid_rst_any", {31'h0, pend_any_b}, 32'h0);
    model_clock();
    @(negedge clk);
    w0_en = 0; w1_en = 0; mark_en = 0;
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n && $urandom_range(0, 2) == 0) rst_n = 1'b1;
      w0_en = 1'($urandom_range(0, 1)); w0_addr = 5'(pick_addr()); w0_data = $urandom;
      w1_en = 1'($urandom_range(0, 1)); w1_addr = 5'(pick_addr()); w1_data = $urandom;
      mark_en = 1'($urandom_range(0, 1)); mark_addr = 5'(pick_addr());
      r_addr = {5'(pick_addr()), 5'(pick_addr())};
      #1 check_all("rnd");
      if (rst_n && $urandom_range(0, 149) == 0) begin
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all("rnd_rst");
      end
      model_clock();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
